// File: rtl/id_ex_pipeline_register.sv
// Decode-to-Execute pipeline register: captures decoded control, operands and
// register indices, with hazard-unit stall (hold) and flush (bubble) controls.
module id_ex_pipeline_register #(
  parameter int unsigned XLEN    = 32,
  parameter logic [2:0]  NOP_ALU = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic            memwrite;
    logic            jump;
    logic            branch;
    logic [2:0]      alucontrol;
    logic            alusrc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] immext;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } stage_t;

  stage_t stage_r;
  stage_t next_s;
  stage_t bubble_s;
  stage_t load_s;

  // Bubble contents shared by reset and flush: nothing commits, ALU idles.
  always_comb begin
    bubble_s            = '0;
    bubble_s.alucontrol = NOP_ALU;
  end

  // Decode-side capture; side-effect enables are gated so a non-valid slot can never commit.
  always_comb begin
    load_s.valid      = ValidD;
    load_s.regwrite   = RegWriteD & ValidD;
    load_s.resultsrc  = ResultSrcD;
    load_s.memwrite   = MemWriteD & ValidD;
    load_s.jump       = JumpD & ValidD;
    load_s.branch     = BranchD & ValidD;
    load_s.alucontrol = ALUControlD;
    load_s.alusrc     = ALUSrcD;
    load_s.rd1        = RD1D;
    load_s.rd2        = RD2D;
    load_s.pc         = PCD;
    load_s.immext     = ImmExtD;
    load_s.pcplus4    = PCPlus4D;
    load_s.rs1        = Rs1D;
    load_s.rs2        = Rs2D;
    load_s.rd         = RdD;
  end

  // Next-state selection: flush beats stall, stall beats a normal load.
  always_comb begin
    next_s = stage_r;
    if (FlushE) begin
      next_s = bubble_s;
    end else if (StallE) begin
      next_s = stage_r;
    end else begin
      next_s = load_s;
    end
  end

  // Stage register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= bubble_s;
    end else begin
      stage_r <= next_s;
    end
  end

  assign ValidE      = stage_r.valid;
  assign RegWriteE   = stage_r.regwrite;
  assign ResultSrcE  = stage_r.resultsrc;
  assign MemWriteE   = stage_r.memwrite;
  assign JumpE       = stage_r.jump;
  assign BranchE     = stage_r.branch;
  assign ALUControlE = stage_r.alucontrol;
  assign ALUSrcE     = stage_r.alusrc;
  assign RD1E        = stage_r.rd1;
  assign RD2E        = stage_r.rd2;
  assign PCE         = stage_r.pc;
  assign ImmExtE     = stage_r.immext;
  assign PCPlus4E    = stage_r.pcplus4;
  assign Rs1E        = stage_r.rs1;
  assign Rs2E        = stage_r.rs2;
  assign RdE         = stage_r.rd;

endmodule
